simd_issue_sequencer: RTL and testbench
=======================================

# simd_issue_sequencer

Sequencer in front of the 64-core SIMD aggregation array. It collects per-core aggregation tasks from the edge-fetch front end and packs them into one 8-bit-per-core instruction beat. It then issues the beat to the array and waits for every enabled core to report completion before opening the next beat. It also tracks each core's aggregation progress, so the array knows whether a core starts a new accumulation (first operand from the instruction) or continues one (first operand from the previous result).

## Interface
- CORE_NUM, 64, number of SIMD cores (power of two)
- CORE_W, 6, width of the core index, log2(CORE_NUM)
- TIMEOUT, 16, idle cycles in COLLECT before a partial beat is issued (≥2)
- CNT_W, 8, per-core aggregation counter width
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- task_valid  input  1  task offered
- task_ready  output  1  task accepted when task_valid && task_ready
- task_core  input  CORE_W  target core index
- task_op  input  1  opcode bit for the core
- task_tag  input  1  last task of this core's current aggregation
- task_addr  input  6  buffer address (bit 5 always 0 from source; passed through)
- flush  input  1  force issue of the pending partial beat
- core_done  input  CORE_NUM  per-core completion pulse or level from the array
- instr_o  output  8*CORE_NUM  packed beat: [8i+7]=op, [8i+6]=tag, [8i+5:8i]=addr
- en_o  output  CORE_NUM  cores carrying a valid instruction this beat
- first_o  output  CORE_NUM  core i starts a new aggregation (counter==0)
- instr_valid  output  1  one-cycle strobe, beat valid
- busy  output  1  FSM not in COLLECT
- beat_cnt  output  16  beats retired, wraps

## Operation
- Per-core one-entry slot: slot_full[i], op, tag, addr. Per-core counter agg_cnt[i] (CNT_W bits). Per-core done_seen[i].
- FSM states: COLLECT, ISSUE, WAIT, RETIRE.
- COLLECT:
  - task_ready = !slot_full[task_core]. This is a combinational valid→ready path through task_core.
  - An accepted task writes its core's slot.
  - Idle counter resets on every accept and increments otherwise. It is held at 0 while no slot is full.
  - COLLECT→ISSUE when any of the following holds:
    - all slots are full after this cycle's write;
    - flush=1 and any slot is full after this cycle's write;
    - the idle counter reaches TIMEOUT-1 with any slot full.
  - A task accepted in the transition cycle is included in the beat.
  - flush with all slots empty is ignored.
- ISSUE (1 cycle):
  - instr_valid=1 and en_o=slot_full.
  - instr_o holds slot contents for enabled cores and 8'h00 for the others.
  - first_o[i] = en_o[i] && agg_cnt[i]==0.
  - done_seen is cleared. Next state is WAIT.
- WAIT:
  - done_seen[i] |= core_done[i] & en_o[i]. core_done for cores that are not enabled is ignored.
  - Go to RETIRE when (done_seen | (core_done&en_o)) covers en_o.
  - instr_o, en_o and first_o hold their ISSUE values through WAIT.
- RETIRE (1 cycle):
  - For each enabled core: if tag=1, agg_cnt←0; otherwise agg_cnt←agg_cnt+1, saturating at all-ones.
  - Clear all slots, beat_cnt+1, then go to COLLECT.
- task_ready=0 in ISSUE, WAIT and RETIRE.

## Timing
- Reset (rst=0, asynchronous):
  - FSM enters COLLECT.
  - All slots, agg_cnt, done_seen, the idle counter and beat_cnt are cleared to 0.
  - instr_o=0, en_o=0, first_o=0, instr_valid=0, busy=0.
  - A reset mid-WAIT discards the beat. The array must be reset together with this block.
- Outputs are registered except task_ready.
- Latency:
  - With a full beat, the last accept edge is followed by instr_valid in the next cycle.
  - With a partial beat, the last accept edge is followed by TIMEOUT-1 idle cycles, then ISSUE.
- Minimum beat period is 4 cycles: ISSUE, WAIT (done in the same cycle), RETIRE, then COLLECT with one accept.
- core_done arriving in the ISSUE cycle is not captured. Completion is sampled only in WAIT.
- busy=1 in ISSUE, WAIT and RETIRE.
- beat_cnt wraps from 16'hFFFF to 0.

## Test plan
- Reset, then 64 tasks for cores 0..63 (op=1, tag=0, addr=i[4:0]), back-to-back with task_valid=1. Expect:
  - instr_valid one cycle after the 64th accept;
  - en_o=all ones, instr_o[8i+7:8i]=8'h80|i[4:0], first_o=all ones;
  - all core_done set → RETIRE, beat_cnt=1.
- Repeat the same beat three times with tag=0, then once with tag=1. Expect:
  - first_o=all ones on beat 1 and all zeros on beats 2–4;
  - a fifth beat shows first_o=all ones again.
- Tasks to cores 3 and 7 only, no flush. Expect:
  - ISSUE exactly TIMEOUT-1 idle cycles after the second accept;
  - en_o=0x88, other lanes' instr_o=0.
  - Repeat using flush in the same cycle as the core-7 accept: ISSUE on the next cycle.
- A second task to core 5 while its slot is full. Expect task_ready=0 and the task held until after RETIRE.
- Beat with en_o[0]=en_o[1]=1, core_done[0] pulsed at WAIT cycle 1 and core_done[1] at cycle 4, plus a spurious core_done[2]. Expect RETIRE exactly after cycle 4 and no effect from core 2.
- Assert rst mid-WAIT. Expect all outputs 0 immediately, busy=0, beat_cnt=0, and next-cycle task_ready=1 for any core.

Source files
------------

// File: rtl/simd_issue_sequencer.sv
// SIMD issue sequencer: packs per-core aggregation tasks into one 8-bit-per-core beat,
// issues it to the array, waits for all enabled cores to complete, then retires it while
// tracking each core's aggregation progress (new accumulation vs. continuation).
module simd_issue_sequencer #(
    parameter int unsigned CORE_NUM = 64,
    parameter int unsigned CORE_W   = 6,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    task_valid,
    output logic                    task_ready,
    input  logic [CORE_W-1:0]       task_core,
    input  logic                    task_op,
    input  logic                    task_tag,
    input  logic [5:0]              task_addr,
    input  logic                    flush,
    input  logic [CORE_NUM-1:0]     core_done,
    output logic [8*CORE_NUM-1:0]   instr_o,
    output logic [CORE_NUM-1:0]     en_o,
    output logic [CORE_NUM-1:0]     first_o,
    output logic                    instr_valid,
    output logic                    busy,
    output logic [15:0]             beat_cnt
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT) + 1;
    // The counter value seen in the last idle cycle; the increment at that edge would
    // reach TIMEOUT-1, which is where the partial beat gets issued.
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 2);

    typedef enum logic [1:0] {StCollect, StIssue, StWait, StRetire} state_e;

    state_e                 r_state;
    logic [CORE_NUM-1:0]    r_slot_full;
    logic [CORE_NUM-1:0]    r_slot_op;
    logic [CORE_NUM-1:0]    r_slot_tag;
    logic [5:0]             r_slot_addr [CORE_NUM];
    logic [CNT_W-1:0]       r_agg_cnt   [CORE_NUM];
    logic [CORE_NUM-1:0]    r_done_seen;
    logic [IDLE_W-1:0]      r_idle_cnt;
    logic [15:0]            r_beat_cnt;
    logic [8*CORE_NUM-1:0]  r_instr;
    logic [CORE_NUM-1:0]    r_en;
    logic [CORE_NUM-1:0]    r_first;
    logic                   r_instr_valid;
    logic                   r_busy;

    logic                   w_accept;
    logic [CORE_NUM-1:0]    w_sel;
    logic [CORE_NUM-1:0]    w_write;
    logic [CORE_NUM-1:0]    w_full_nxt;
    logic [CORE_NUM-1:0]    w_agg_zero;
    logic [8*CORE_NUM-1:0]  w_instr_nxt;
    logic                   w_timeout;
    logic                   w_issue;
    logic                   w_done_all;

    // Ready is combinational through task_core so a free slot accepts in the same cycle.
    assign task_ready = (r_state == StCollect) && !r_slot_full[task_core];
    assign w_accept   = task_valid && task_ready;
    assign w_sel      = CORE_NUM'(1) << task_core;
    assign w_write    = w_accept ? w_sel : '0;
    assign w_full_nxt = r_slot_full | w_write;
    assign w_timeout  = !w_accept && (|r_slot_full) && (r_idle_cnt == IDLE_LAST);
    assign w_issue    = (r_state == StCollect) &&
                        ((&w_full_nxt) || (flush && (|w_full_nxt)) || w_timeout);
    assign w_done_all = (((r_done_seen | (core_done & r_en)) & r_en) == r_en);

    assign instr_o     = r_instr;
    assign en_o        = r_en;
    assign first_o     = r_first;
    assign instr_valid = r_instr_valid;
    assign busy        = r_busy;
    assign beat_cnt    = r_beat_cnt;

    // Pack the beat from post-write slot contents so a task accepted on the issue edge rides along.
    always_comb begin
        w_instr_nxt = '0;
        w_agg_zero  = '0;
        for (int i = 0; i < int'(CORE_NUM); i++) begin
            w_agg_zero[i] = (r_agg_cnt[i] == '0);
            if (w_write[i]) begin
                w_instr_nxt[8*i +: 8] = {task_op, task_tag, task_addr};
            end else if (r_slot_full[i]) begin
                w_instr_nxt[8*i +: 8] = {r_slot_op[i], r_slot_tag[i], r_slot_addr[i]};
            end
        end
    end

    // Per-core task slots: written on accept, all cleared when the beat retires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot_full <= '0;
            r_slot_op   <= '0;
            r_slot_tag  <= '0;
            for (int i = 0; i < int'(CORE_NUM); i++) begin
                r_slot_addr[i] <= '0;
            end
        end else if (r_state == StRetire) begin
            r_slot_full <= '0;
        end else begin
            for (int i = 0; i < int'(CORE_NUM); i++) begin
                if (w_write[i]) begin
                    r_slot_full[i] <= 1'b1;
                    r_slot_op[i]   <= task_op;
                    r_slot_tag[i]  <= task_tag;
                    r_slot_addr[i] <= task_addr;
                end
            end
        end
    end

    // Aggregation progress: a tagged task closes the accumulation, otherwise count up (saturating).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(CORE_NUM); i++) begin
                r_agg_cnt[i] <= '0;
            end
        end else if (r_state == StRetire) begin
            for (int i = 0; i < int'(CORE_NUM); i++) begin
                if (r_en[i]) begin
                    if (r_slot_tag[i]) begin
                        r_agg_cnt[i] <= '0;
                    end else if (r_agg_cnt[i] != '1) begin
                        r_agg_cnt[i] <= r_agg_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Beat FSM with registered outputs, idle timer, completion tracking and beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= StCollect;
            r_done_seen   <= '0;
            r_idle_cnt    <= '0;
            r_beat_cnt    <= '0;
            r_instr       <= '0;
            r_en          <= '0;
            r_first       <= '0;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            unique case (r_state)
                StCollect: begin
                    if (w_issue) begin
                        r_state       <= StIssue;
                        r_instr       <= w_instr_nxt;
                        r_en          <= w_full_nxt;
                        r_first       <= w_full_nxt & w_agg_zero;
                        r_instr_valid <= 1'b1;
                        r_busy        <= 1'b1;
                        r_idle_cnt    <= '0;
                    end else if (w_accept || !(|r_slot_full)) begin
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                    end
                end
                StIssue: begin
                    // Completion seen during the issue cycle is deliberately not captured.
                    r_instr_valid <= 1'b0;
                    r_done_seen   <= '0;
                    r_state       <= StWait;
                end
                StWait: begin
                    r_done_seen <= r_done_seen | (core_done & r_en);
                    if (w_done_all) begin
                        r_state <= StRetire;
                    end
                end
                StRetire: begin
                    r_beat_cnt <= r_beat_cnt + 16'd1;
                    r_instr    <= '0;
                    r_en       <= '0;
                    r_first    <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= StCollect;
                end
                default: begin
                    r_state <= StCollect;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simd_issue_sequencer.sv
// Scoreboard bench for simd_issue_sequencer: stimulus pushes expected beats, a monitor
// pops and compares them whenever instr_valid is seen.
module tb_simd_issue_sequencer;

    localparam int CN = 64;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           task_valid = 1'b0;
    logic           task_ready;
    logic [5:0]     task_core = '0;
    logic           task_op = 1'b0;
    logic           task_tag = 1'b0;
    logic [5:0]     task_addr = '0;
    logic           flush = 1'b0;
    logic [CN-1:0]  core_done = '1;
    logic [8*CN-1:0] instr_o;
    logic [CN-1:0]  en_o;
    logic [CN-1:0]  first_o;
    logic           instr_valid;
    logic           busy;
    logic [15:0]    beat_cnt;

    simd_issue_sequencer #(
        .CORE_NUM (CN),
        .CORE_W   (6),
        .TIMEOUT  (TO),
        .CNT_W    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .task_valid  (task_valid),
        .task_ready  (task_ready),
        .task_core   (task_core),
        .task_op     (task_op),
        .task_tag    (task_tag),
        .task_addr   (task_addr),
        .flush       (flush),
        .core_done   (core_done),
        .instr_o     (instr_o),
        .en_o        (en_o),
        .first_o     (first_o),
        .instr_valid (instr_valid),
        .busy        (busy),
        .beat_cnt    (beat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CN-1:0]   en;
        logic [8*CN-1:0] instr;
        logic [CN-1:0]   first;
        int              cyc;
    } exp_t;

    exp_t            q[$];
    exp_t            mon_e;
    int              n_checks = 0;
    int              n_pass = 0;
    int              cyc = 0;
    logic [CN-1:0]   m_en = '0;
    logic [CN-1:0]   m_tag = '0;
    logic [8*CN-1:0] m_instr = '0;
    int              agg[CN];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [8*CN-1:0] act,
                       input logic [8*CN-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Offer one task and hold it until accepted; returns just after the accepting edge.
    task automatic send(input int core, input logic op, input logic tag,
                        input logic [5:0] addr, input logic fl, output int acc);
        bit got = 0;
        @(negedge clk);
        task_valid = 1'b1;
        task_core  = core[5:0];
        task_op    = op;
        task_tag   = tag;
        task_addr  = addr;
        flush      = fl;
        acc        = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            #1;
            if (task_ready) begin
                acc = cyc;
                @(posedge clk);
                got = 1;
            end else begin
                @(negedge clk);
            end
        end
        n_checks++;
        if (got) begin
            n_pass++;
            m_en[core]            = 1'b1;
            m_tag[core]           = tag;
            m_instr[8*core +: 8]  = {op, tag, addr};
        end else begin
            $display("FAIL accept_timeout: core %0d got no ready required ready", core);
        end
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        task_valid = 1'b0;
        flush      = 1'b0;
    endtask

    // Snapshot the modelled slots as the next expected beat and advance the progress model.
    task automatic push_beat(input int issue_cyc);
        exp_t e;
        e.en    = m_en;
        e.instr = m_instr;
        e.first = '0;
        e.cyc   = issue_cyc;
        for (int i = 0; i < CN; i++) begin
            if (m_en[i]) begin
                if (agg[i] == 0) e.first[i] = 1'b1;
                agg[i] = m_tag[i] ? 0 : ((agg[i] < 255) ? agg[i] + 1 : 255);
            end
        end
        q.push_back(e);
        m_en    = '0;
        m_tag   = '0;
        m_instr = '0;
    endtask

    task automatic wait_retire(input int exp_bc);
        bit seen = 0;
        bit done = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (busy) seen = 1;
            else @(negedge clk);
        end
        for (int k = 0; k < 100 && seen && !done; k++) begin
            if (!busy) done = 1;
            else @(negedge clk);
        end
        n_checks++;
        if (done) n_pass++;
        else $display("FAIL retire_timeout: busy_seen=%0d retired=%0d required 1/1", seen, done);
        chk("beat_cnt", 512'(beat_cnt), 512'(exp_bc));
    endtask

    // Monitor: every issue strobe must match the oldest expected beat, including its cycle.
    always @(negedge clk) begin
        if (rst && instr_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_beat: got en %h required no beat", en_o);
            end else begin
                mon_e = q.pop_front();
                chk("beat_en", 512'(en_o), 512'(mon_e.en));
                chk("beat_instr", instr_o, mon_e.instr);
                chk("beat_first", 512'(first_o), 512'(mon_e.first));
                chk("beat_cycle", 512'(cyc), 512'(mon_e.cyc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int a;
        int a_b;
        for (int i = 0; i < CN; i++) agg[i] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_instr", instr_o, '0);
        chk("rst_en", 512'(en_o), '0);
        chk("rst_first", 512'(first_o), '0);
        chk("rst_valid", 512'(instr_valid), '0);
        chk("rst_busy", 512'(busy), '0);
        chk("rst_beat_cnt", 512'(beat_cnt), '0);
        rst = 1'b1;

        // Flush with no pending slots must not start a beat
        @(negedge clk);
        flush = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush_empty_busy", 512'(busy), '0);
        flush = 1'b0;

        // Five full beats: tags 0,0,0,1,1 -> first all ones, zeros, zeros, zeros, all ones
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < CN; i++) begin
                send(i, 1'b1, (b >= 3), 6'(i % 32), 1'b0, a);
            end
            push_beat(a + 1);
            idle_inputs();
            wait_retire(b + 1);
        end

        // Partial beat to cores 3 and 7, issued by the idle timeout (lanes 0x55 and 0x8A)
        send(3, 1'b0, 1'b1, 6'h15, 1'b0, a);
        send(7, 1'b1, 1'b0, 6'h0A, 1'b0, a);
        push_beat(a + TO);
        idle_inputs();
        wait_retire(6);

        // Same pair, flush with the core-7 accept issues on the next cycle
        send(3, 1'b1, 1'b0, 6'h01, 1'b0, a);
        send(7, 1'b0, 1'b1, 6'h1E, 1'b1, a);
        push_beat(a + 1);
        idle_inputs();
        wait_retire(7);

        // Second task to a full slot is back-pressured until the beat retires
        send(5, 1'b1, 1'b0, 6'h05, 1'b0, a);
        push_beat(a + TO);
        @(negedge clk);
        task_valid = 1'b1;
        task_core  = 6'd5;
        #1;
        chk("full_slot_ready", 512'(task_ready), '0);
        send(5, 1'b0, 1'b0, 6'h06, 1'b0, a_b);
        chk("held_task_accept_cycle", 512'(a_b), 512'(a + TO + 3));
        push_beat(a_b + TO);
        idle_inputs();
        wait_retire(9);

        // Completion timing: core 0 done at WAIT cycle 1, core 1 at cycle 4, core 2 spurious
        core_done = '0;
        send(0, 1'b1, 1'b1, 6'h00, 1'b0, a);
        send(1, 1'b1, 1'b1, 6'h01, 1'b1, a);
        push_beat(a + 1);
        @(negedge clk);                     // ISSUE
        task_valid = 1'b0;
        flush      = 1'b0;
        core_done  = 64'h4;
        @(negedge clk);                     // WAIT 1
        core_done  = 64'h5;
        @(negedge clk);                     // WAIT 2
        core_done  = 64'h4;
        @(negedge clk);                     // WAIT 3
        @(negedge clk);                     // WAIT 4
        core_done  = 64'h6;
        @(negedge clk);                     // RETIRE
        core_done  = '0;
        chk("retire_not_early", 512'(busy), 512'(1));
        @(negedge clk);                     // back in COLLECT
        chk("retire_after_wait4", 512'(busy), '0);
        chk("beat_cnt_done_test", 512'(beat_cnt), 512'(10));

        // Reset in the middle of WAIT discards the beat
        send(9, 1'b1, 1'b0, 6'h09, 1'b1, a);
        push_beat(a + 1);
        idle_inputs();                      // ISSUE
        @(negedge clk);                     // WAIT 1
        @(negedge clk);                     // WAIT 2
        rst = 1'b0;
        for (int i = 0; i < CN; i++) agg[i] = 0;
        #1;
        chk("midrst_instr", instr_o, '0);
        chk("midrst_en", 512'(en_o), '0);
        chk("midrst_first", 512'(first_o), '0);
        chk("midrst_valid", 512'(instr_valid), '0);
        chk("midrst_busy", 512'(busy), '0);
        chk("midrst_beat_cnt", 512'(beat_cnt), '0);
        @(negedge clk);
        rst = 1'b1;
        task_valid = 1'b1;
        task_core  = 6'd0;
        #1;
        chk("postrst_ready_core0", 512'(task_ready), 512'(1));
        task_core  = 6'd63;
        #1;
        chk("postrst_ready_core63", 512'(task_ready), 512'(1));
        task_core  = 6'd9;
        #1;
        chk("postrst_ready_core9", 512'(task_ready), 512'(1));
        task_valid = 1'b0;

        // Progress counters restart after reset: core 5 starts a new aggregation
        core_done = '1;
        send(5, 1'b1, 1'b1, 6'h05, 1'b1, a);
        push_beat(a + 1);
        idle_inputs();
        wait_retire(1);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 512'(q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
